unidad_control_multiciclo: RTL and testbench

Parametrised multicycle control unit for the CISC datapath. It sequences fetch, decode, ALU, load/store and branch instructions, and drives the datapath's register-load, mux-select, register-file and ALU-function controls. It adds a ready/request memory handshake with arbitrary wait states, trap states for illegal opcodes and HALT, and an optional memory timeout. It sits between the instruction register / status flag and the datapath (PC, AR, DR, IR, S, register file, ALU).

---
 rtl/unidad_control_multiciclo.sv | 191 +++++++++++++++++++
 tb/tb_unidad_control_multiciclo.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/unidad_control_multiciclo.sv
// Multicycle control unit: fetch/decode/execute sequencing with a ready/request memory handshake.
// Optional per-access memory timeout enabled by defining UCM_MEM_TIMEOUT_EN.
module unidad_control_multiciclo #(
    parameter int IW          = 16,
    parameter int RAW         = 3,
    parameter int FW          = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic           Reloj,
    input  logic           Reiniciar,
    input  logic [IW-1:0]  Instruccion,
    input  logic           StatusFlag,
    input  logic           MemReady,
    output logic           MemReq,
    output logic           MemWrite,
    output logic           LoadAR,
    output logic           SelectAR,
    output logic           LoadDR,
    output logic           SelectDR,
    output logic           LoadPC,
    output logic [1:0]     SelectPC,
    output logic           LoadIR,
    output logic           LoadS,
    output logic           WriteEnable,
    output logic           WriteSelect,
    output logic [RAW-1:0] WriteAddress,
    output logic [RAW-1:0] ReadAddressA,
    output logic [RAW-1:0] ReadAddressB,
    output logic [FW-1:0]  Fun,
    output logic           Halted,
    output logic           Error
);

    typedef enum logic [3:0] {
        ST_RST, ST_FETCH_REQ, ST_FETCH_WAIT, ST_DECODE, ST_EXEC, ST_WB_ALU,
        ST_MEM_ADDR, ST_MEM_RD, ST_WB_MEM, ST_MEM_WR, ST_JUMP, ST_HALT, ST_ERROR
    } stateT;

    localparam logic [3:0] OP_LOAD   = 4'h8;
    localparam logic [3:0] OP_STORE  = 4'h9;
    localparam logic [3:0] OP_JUMP   = 4'hA;
    localparam logic [3:0] OP_BRANCH = 4'hB;
    localparam logic [3:0] OP_HALT   = 4'hF;

    stateT      state, nextState;
    logic [3:0] op;
    logic       inWait;
    logic       waitExpired;
    logic       unusedInstr;

    assign op           = Instruccion[IW-1 -: 4];
    assign WriteAddress = Instruccion[IW-5 -: RAW];
    assign ReadAddressA = Instruccion[IW-5-RAW -: RAW];
    assign ReadAddressB = Instruccion[IW-5-2*RAW -: RAW];
    assign unusedInstr  = ^Instruccion;

    assign inWait = (state == ST_FETCH_WAIT) || (state == ST_MEM_RD) || (state == ST_MEM_WR);

`ifdef UCM_MEM_TIMEOUT_EN
    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    logic [TW-1:0] waitCnt;

    // Counts wait cycles of the current access; idle states hold it cleared.
    always_ff @(posedge Reloj or negedge Reiniciar) begin
        if (!Reiniciar) begin
            waitCnt <= '0;
        end else if (!inWait) begin
            waitCnt <= '0;
        end else if (!MemReady) begin
            waitCnt <= waitCnt + 1'b1;
        end
    end

    assign waitExpired = inWait && (waitCnt == TW'(MEM_TIMEOUT - 1));
`else
    localparam int unusedTimeout = MEM_TIMEOUT;
    assign waitExpired = 1'b0;
`endif

    always_ff @(posedge Reloj or negedge Reiniciar) begin
        if (!Reiniciar) begin
            state <= ST_RST;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState   = state;
        MemReq      = 1'b0;
        MemWrite    = 1'b0;
        LoadAR      = 1'b0;
        SelectAR    = 1'b0;
        LoadDR      = 1'b0;
        SelectDR    = 1'b0;
        LoadPC      = 1'b0;
        SelectPC    = 2'b00;
        LoadIR      = 1'b0;
        LoadS       = 1'b0;
        WriteEnable = 1'b0;
        WriteSelect = 1'b0;
        Fun         = '0;
        Halted      = 1'b0;
        Error       = 1'b0;

        unique case (state)
            ST_RST: nextState = ST_FETCH_REQ;
            ST_FETCH_REQ: begin
                LoadAR    = 1'b1;
                nextState = ST_FETCH_WAIT;
            end
            ST_FETCH_WAIT: begin
                MemReq = 1'b1;
                if (MemReady) begin
                    LoadIR    = 1'b1;
                    LoadPC    = 1'b1;
                    SelectPC  = 2'b01;
                    nextState = ST_DECODE;
                end else if (waitExpired) begin
                    nextState = ST_ERROR;
                end
            end
            ST_DECODE: begin
                if (!op[3]) begin
                    nextState = ST_EXEC;
                end else begin
                    unique case (op)
                        OP_LOAD, OP_STORE: nextState = ST_MEM_ADDR;
                        OP_JUMP:           nextState = ST_JUMP;
                        OP_BRANCH:         nextState = StatusFlag ? ST_JUMP : ST_FETCH_REQ;
                        OP_HALT:           nextState = ST_HALT;
                        default:           nextState = ST_ERROR;
                    endcase
                end
            end
            ST_EXEC: begin
                Fun       = FW'(op[2:0]);
                LoadS     = 1'b1;
                nextState = ST_WB_ALU;
            end
            ST_WB_ALU: begin
                WriteEnable = 1'b1;
                nextState   = ST_FETCH_REQ;
            end
            ST_MEM_ADDR: begin
                LoadAR   = 1'b1;
                SelectAR = 1'b1;
                if (op == OP_STORE) begin
                    LoadDR    = 1'b1;
                    SelectDR  = 1'b1;
                    nextState = ST_MEM_WR;
                end else begin
                    nextState = ST_MEM_RD;
                end
            end
            ST_MEM_RD: begin
                MemReq = 1'b1;
                if (MemReady) begin
                    LoadDR    = 1'b1;
                    nextState = ST_WB_MEM;
                end else if (waitExpired) begin
                    nextState = ST_ERROR;
                end
            end
            ST_WB_MEM: begin
                WriteEnable = 1'b1;
                WriteSelect = 1'b1;
                nextState   = ST_FETCH_REQ;
            end
            ST_MEM_WR: begin
                MemReq   = 1'b1;
                MemWrite = 1'b1;
                if (MemReady) begin
                    nextState = ST_FETCH_REQ;
                end else if (waitExpired) begin
                    nextState = ST_ERROR;
                end
            end
            ST_JUMP: begin
                // Shared target state: JUMP takes register A, a taken BRANCH takes PC+offset.
                LoadPC    = 1'b1;
                SelectPC  = (op == OP_JUMP) ? 2'b11 : 2'b10;
                nextState = ST_FETCH_REQ;
            end
            ST_HALT:  Halted = 1'b1;
            ST_ERROR: Error  = 1'b1;
            default:  nextState = ST_RST;
        endcase
    end

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Directed bench for unidad_control_multiciclo: per-cycle control-word checks against hand-computed vectors.
module tb_unidad_control_multiciclo;

    localparam int IW = 16;
    localparam int RAW = 3;
    localparam int FW = 4;
    localparam int MT = 4;

    localparam logic [14:0] C_REQ = 15'h4000;
    localparam logic [14:0] C_WR  = 15'h2000;
    localparam logic [14:0] C_LAR = 15'h1000;
    localparam logic [14:0] C_SAR = 15'h0800;
    localparam logic [14:0] C_LDR = 15'h0400;
    localparam logic [14:0] C_SDR = 15'h0200;
    localparam logic [14:0] C_LPC = 15'h0100;
    localparam logic [14:0] C_PC1 = 15'h0040;
    localparam logic [14:0] C_PCO = 15'h0080;
    localparam logic [14:0] C_PCA = 15'h00C0;
    localparam logic [14:0] C_LIR = 15'h0020;
    localparam logic [14:0] C_LS  = 15'h0010;
    localparam logic [14:0] C_WE  = 15'h0008;
    localparam logic [14:0] C_WS  = 15'h0004;
    localparam logic [14:0] C_HLT = 15'h0002;
    localparam logic [14:0] C_ERR = 15'h0001;
    localparam logic [14:0] C_FETCH = C_REQ | C_LIR | C_LPC | C_PC1;

    logic           Reloj = 1'b0;
    logic           Reiniciar = 1'b0;
    logic [IW-1:0]  Instruccion = '0;
    logic           StatusFlag = 1'b0;
    logic           MemReady = 1'b0;
    logic           MemReq, MemWrite, LoadAR, SelectAR, LoadDR, SelectDR, LoadPC;
    logic [1:0]     SelectPC;
    logic           LoadIR, LoadS, WriteEnable, WriteSelect, Halted, Error;
    logic [RAW-1:0] WriteAddress, ReadAddressA, ReadAddressB;
    logic [FW-1:0]  Fun;
    logic [14:0]    ctl;

    int nVec = 0;
    int nErr = 0;

    unidad_control_multiciclo #(.IW(IW), .RAW(RAW), .FW(FW), .MEM_TIMEOUT(MT)) dut (
        .Reloj(Reloj), .Reiniciar(Reiniciar), .Instruccion(Instruccion),
        .StatusFlag(StatusFlag), .MemReady(MemReady),
        .MemReq(MemReq), .MemWrite(MemWrite), .LoadAR(LoadAR), .SelectAR(SelectAR),
        .LoadDR(LoadDR), .SelectDR(SelectDR), .LoadPC(LoadPC), .SelectPC(SelectPC),
        .LoadIR(LoadIR), .LoadS(LoadS), .WriteEnable(WriteEnable), .WriteSelect(WriteSelect),
        .WriteAddress(WriteAddress), .ReadAddressA(ReadAddressA), .ReadAddressB(ReadAddressB),
        .Fun(Fun), .Halted(Halted), .Error(Error)
    );

    assign ctl = {MemReq, MemWrite, LoadAR, SelectAR, LoadDR, SelectDR, LoadPC, SelectPC,
                  LoadIR, LoadS, WriteEnable, WriteSelect, Halted, Error};

    always #5 Reloj = ~Reloj;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive this cycle's inputs just after the edge, then compare {controls, Fun}.
    task automatic step(input string tag, input logic rdy, input logic flag,
                        input logic [14:0] expCtl, input logic [3:0] expFun);
        @(posedge Reloj);
        #2;
        MemReady   = rdy;
        StatusFlag = flag;
        #1;
        chk(tag, {13'b0, ctl, Fun}, {13'b0, expCtl, expFun});
    endtask

    task automatic doReset(input string tag);
        @(posedge Reloj);
        #2;
        Reiniciar = 1'b0;
        MemReady  = 1'b0;
        #1;
        chk(tag, {13'b0, ctl, Fun}, 32'h0);
        @(posedge Reloj);
        #2;
        Reiniciar = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        doReset("reset");

        // ALU op1 rd=1 ra=2 rb=3
        Instruccion = 16'h1298;
        step("alu.c1.fetchReq", 1, 0, C_LAR, 0);
        step("alu.c2.fetchWait", 1, 0, C_FETCH, 0);
        step("alu.c3.decode", 1, 0, 15'h0, 0);
        step("alu.c4.exec", 1, 0, C_LS, 4'd1);
        step("alu.c5.wb", 1, 0, C_WE, 0);
        chk("alu.wa", WriteAddress, 1);
        chk("alu.ra", ReadAddressA, 2);
        chk("alu.rb", ReadAddressB, 3);
        step("alu.c6.fetchReq", 1, 0, C_LAR, 0);

        // LOAD with three data wait states
        Instruccion = 16'h8440;
        step("ld.fetchWait", 1, 0, C_FETCH, 0);
        step("ld.decode", 1, 0, 15'h0, 0);
        step("ld.memAddr", 1, 0, C_LAR | C_SAR, 0);
        chk("ld.ra", ReadAddressA, 1);
        step("ld.wait1", 0, 0, C_REQ, 0);
        step("ld.wait2", 0, 0, C_REQ, 0);
        step("ld.wait3", 0, 0, C_REQ, 0);
        step("ld.ready", 1, 0, C_REQ | C_LDR, 0);
        step("ld.wb", 1, 0, C_WE | C_WS, 0);
        step("ld.fetchReq", 1, 0, C_LAR, 0);

        // STORE with one data wait state
        Instruccion = 16'h9000;
        step("st.fetchWait", 1, 0, C_FETCH, 0);
        step("st.decode", 1, 0, 15'h0, 0);
        step("st.memAddr", 1, 0, C_LAR | C_SAR | C_LDR | C_SDR, 0);
        step("st.wait", 0, 0, C_REQ | C_WR, 0);
        step("st.ready", 1, 0, C_REQ | C_WR, 0);
        step("st.fetchReq", 1, 0, C_LAR, 0);

        Instruccion = 16'hB000;
        step("brNt.fetchWait", 1, 0, C_FETCH, 0);
        step("brNt.decode", 1, 0, 15'h0, 0);
        step("brNt.fetchReq", 1, 0, C_LAR, 0);
        step("brT.fetchWait", 1, 0, C_FETCH, 0);
        step("brT.decode", 1, 1, 15'h0, 0);
        step("brT.loadPc", 0, 0, C_LPC | C_PCO, 0);
        step("brT.fetchReq", 0, 0, C_LAR, 0);

        Instruccion = 16'hA000;
        step("jmp.fetchWait", 1, 0, C_FETCH, 0);
        step("jmp.decode", 1, 0, 15'h0, 0);
        step("jmp.loadPc", 1, 0, C_LPC | C_PCA, 0);
        step("jmp.fetchReq", 1, 0, C_LAR, 0);

        // Reset in the middle of a store access
        Instruccion = 16'h9000;
        step("stRst.fetchWait", 1, 0, C_FETCH, 0);
        step("stRst.decode", 1, 0, 15'h0, 0);
        step("stRst.memAddr", 1, 0, C_LAR | C_SAR | C_LDR | C_SDR, 0);
        step("stRst.memWr", 0, 0, C_REQ | C_WR, 0);
        Reiniciar = 1'b0;
        #1;
        chk("stRst.immediate", {13'b0, ctl, Fun}, 32'h0);
        @(posedge Reloj);
        #2;
        chk("stRst.held", {13'b0, ctl, Fun}, 32'h0);
        Reiniciar = 1'b1;
        step("stRst.fetchReq", 1, 0, C_LAR, 0);
        step("stRst.fetchWait", 1, 0, C_FETCH, 0);

        // Illegal opcode, sticky error
        doReset("ill.reset");
        Instruccion = 16'hD000;
        step("ill.fetchReq", 1, 0, C_LAR, 0);
        step("ill.fetchWait", 1, 0, C_FETCH, 0);
        step("ill.decode", 1, 0, 15'h0, 0);
        step("ill.error1", 1, 0, C_ERR, 0);
        step("ill.error2", 1, 1, C_ERR, 0);
        doReset("ill.clear");
        step("ill.refetch", 1, 0, C_LAR, 0);

        Instruccion = 16'hF000;
        step("hlt.fetchWait", 1, 0, C_FETCH, 0);
        step("hlt.decode", 1, 0, 15'h0, 0);
        step("hlt.halt1", 1, 0, C_HLT, 0);
        step("hlt.halt2", 1, 0, C_HLT, 0);
        doReset("hlt.clear");
        step("hlt.refetch", 1, 0, C_LAR, 0);

        // Ready arriving on the fourth fetch wait cycle completes normally in both builds
        Instruccion = 16'h1298;
        step("w4.wait1", 0, 0, C_REQ, 0);
        step("w4.wait2", 0, 0, C_REQ, 0);
        step("w4.wait3", 0, 0, C_REQ, 0);
        step("w4.ready", 1, 0, C_FETCH, 0);
        step("w4.decode", 1, 0, 15'h0, 0);

        doReset("to.reset");
        step("to.fetchReq", 0, 0, C_LAR, 0);
        for (int i = 0; i < MT; i++) begin
            step("to.wait", 0, 0, C_REQ, 0);
        end
`ifdef UCM_MEM_TIMEOUT_EN
        step("to.error", 0, 0, C_ERR, 0);
        step("to.errorSticky", 1, 0, C_ERR, 0);
`else
        for (int i = 0; i < 16; i++) begin
            step("to.unbounded", 0, 0, C_REQ, 0);
        end
        step("to.lateReady", 1, 0, C_FETCH, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
